// File: rtl/smp_pkg.sv
// Shared definitions for the simple 8-bit processor: control FSM states,
// instruction classes, opcode values, ALU select codes and datapath mux
// encodings. Imported by the control unit, the opcode decoder, the ALU and
// the datapath.
package smp_pkg;

  typedef enum logic [3:0] {
    StFetch1, StFetch2, StFetch3, StDecode, StAddr1, StAddr2,
    StOprd, StExec, StStore1, StStore2, StHalt
  } state_e;

  typedef enum logic [2:0] {
    ClsNone, ClsImplied, ClsMemAlu, ClsStore, ClsJump, ClsCondJump, ClsHalt
  } instr_cls_e;

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpLdac = 4'h1;
  localparam logic [3:0] OpStac = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpAnd  = 4'h5;
  localparam logic [3:0] OpOr   = 4'h6;
  localparam logic [3:0] OpXor  = 4'h7;
  localparam logic [3:0] OpInac = 4'h8;
  localparam logic [3:0] OpClac = 4'h9;
  localparam logic [3:0] OpNot  = 4'hA;
  localparam logic [3:0] OpJump = 4'hB;
  localparam logic [3:0] OpJmpz = 4'hC;
  localparam logic [3:0] OpJpnz = 4'hD;
  localparam logic [3:0] OpRsvd = 4'hE;
  localparam logic [3:0] OpHalt = 4'hF;

  localparam logic [6:0] AluClr  = 7'b000_0000;
  localparam logic [6:0] AluPass = 7'b000_0100;
  localparam logic [6:0] AluAdd  = 7'b000_0101;
  localparam logic [6:0] AluInc  = 7'b000_1001;
  localparam logic [6:0] AluSub  = 7'b000_1011;
  localparam logic [6:0] AluAnd  = 7'b100_0000;
  localparam logic [6:0] AluXor  = 7'b101_0000;
  localparam logic [6:0] AluOr   = 7'b110_0000;
  localparam logic [6:0] AluNot  = 7'b111_0000;

  localparam logic BusDr   = 1'b0;
  localparam logic BusAc   = 1'b1;
  localparam logic ArSrcPc = 1'b0;
  localparam logic ArSrcDr = 1'b1;

endpackage

// File: rtl/smp_op_decode.sv
// Combinational opcode decoder.
// Ports:
//   opcode  in  4 : ir[7:4]
//   cls     out   : instruction class steering the control FSM
//   alu_sel out 7 : ALU code used in DECODE (implied-AC ops) or EXEC (memory-ALU ops)
module smp_op_decode
  import smp_pkg::*;
(
  input  logic [3:0] opcode,
  output instr_cls_e cls,
  output logic [6:0] alu_sel
);

  always_comb begin
    cls     = ClsNone;
    alu_sel = AluClr;
    case (opcode)
      OpLdac: begin cls = ClsMemAlu;   alu_sel = AluPass; end
      OpStac: cls = ClsStore;
      OpAdd:  begin cls = ClsMemAlu;   alu_sel = AluAdd;  end
      OpSub:  begin cls = ClsMemAlu;   alu_sel = AluSub;  end
      OpAnd:  begin cls = ClsMemAlu;   alu_sel = AluAnd;  end
      OpOr:   begin cls = ClsMemAlu;   alu_sel = AluOr;   end
      OpXor:  begin cls = ClsMemAlu;   alu_sel = AluXor;  end
      OpInac: begin cls = ClsImplied;  alu_sel = AluInc;  end
      OpClac: begin cls = ClsImplied;  alu_sel = AluClr;  end
      OpNot:  begin cls = ClsImplied;  alu_sel = AluNot;  end
      OpJump: cls = ClsJump;
      OpJmpz: cls = ClsCondJump;
      OpJpnz: cls = ClsCondJump;
      OpHalt: cls = ClsHalt;
      default: cls = ClsNone;  // NOP and the reserved opcode
    endcase
  end

endmodule

// File: rtl/smp_control_unit.sv
// Fetch/decode/execute sequencer with memory request/ready handshake and
// wait-state timeout.
// Ports:
//   clk, reset (sync, active-high)
//   ir[7:0], z, mem_ready                       : status inputs
//   mem_rd, mem_wr                              : memory requests (address AR, write data DR)
//   ar_ld, ar_src, pc_inc, pc_ld, dr_ld, ir_ld,
//   ac_ld, z_ld, bus_sel, alu_sel[6:0]          : datapath controls
//   halted, err                                 : HALT state, sticky memory timeout
module smp_control_unit
  import smp_pkg::*;
#(
  parameter int unsigned WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ir,
  input  logic       z,
  input  logic       mem_ready,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       ar_ld,
  output logic       ar_src,
  output logic       pc_inc,
  output logic       pc_ld,
  output logic       dr_ld,
  output logic       ir_ld,
  output logic       ac_ld,
  output logic       z_ld,
  output logic       bus_sel,
  output logic [6:0] alu_sel,
  output logic       halted,
  output logic       err
);

  localparam int unsigned CntW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
  localparam logic [CntW-1:0] LimitCnt = CntW'(WAIT_LIMIT);

  state_e          state_q, state_d;
  logic [CntW-1:0] wait_q, wait_d;
  logic            err_q, err_d;
  instr_cls_e      cls;
  logic [6:0]      dec_alu_sel;
  logic            branch_taken;
  logic            unused_ir;

  assign unused_ir = ^ir[3:0];

  smp_op_decode u_op_decode (
    .opcode  (ir[7:4]),
    .cls     (cls),
    .alu_sel (dec_alu_sel)
  );

  assign branch_taken = (ir[7:4] == OpJmpz) ? z : !z;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StFetch1;
      wait_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = '0;  // any non-wait state rearms the counter for the next access
    err_d   = err_q;
    mem_rd  = 1'b0;
    mem_wr  = 1'b0;
    ar_ld   = 1'b0;
    ar_src  = ArSrcPc;
    pc_inc  = 1'b0;
    pc_ld   = 1'b0;
    dr_ld   = 1'b0;
    ir_ld   = 1'b0;
    ac_ld   = 1'b0;
    z_ld    = 1'b0;
    bus_sel = BusDr;
    alu_sel = AluClr;
    halted  = 1'b0;
    err     = err_q;

    case (state_q)
      StFetch1: begin
        ar_ld   = 1'b1;
        state_d = StFetch2;
      end
      StFetch2: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          dr_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = StFetch3;
        end
      end
      StFetch3: begin
        ir_ld   = 1'b1;
        state_d = StDecode;
      end
      StDecode: begin
        state_d = StFetch1;
        case (cls)
          ClsImplied: begin
            ac_ld   = 1'b1;
            z_ld    = 1'b1;
            alu_sel = dec_alu_sel;
          end
          ClsHalt: state_d = StHalt;
          ClsCondJump: begin
            if (branch_taken) begin
              ar_ld   = 1'b1;
              state_d = StAddr1;
            end else begin
              pc_inc = 1'b1;  // step over the unused operand byte
            end
          end
          ClsMemAlu, ClsStore, ClsJump: begin
            ar_ld   = 1'b1;
            state_d = StAddr1;
          end
          default: state_d = StFetch1;
        endcase
      end
      StAddr1: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          dr_ld   = 1'b1;
          pc_inc  = 1'b1;
          state_d = StAddr2;
        end
      end
      StAddr2: begin
        if (cls == ClsJump || cls == ClsCondJump) begin
          pc_ld   = 1'b1;
          state_d = StFetch1;
        end else begin
          ar_ld   = 1'b1;
          ar_src  = ArSrcDr;
          state_d = (cls == ClsStore) ? StStore1 : StOprd;
        end
      end
      StOprd: begin
        mem_rd = 1'b1;
        if (mem_ready) begin
          dr_ld   = 1'b1;
          state_d = StExec;
        end
      end
      StExec: begin
        ac_ld   = 1'b1;
        z_ld    = 1'b1;
        alu_sel = dec_alu_sel;
        state_d = StFetch1;
      end
      StStore1: begin
        bus_sel = BusAc;
        dr_ld   = 1'b1;
        state_d = StStore2;
      end
      StStore2: begin
        mem_wr = 1'b1;
        if (mem_ready) state_d = StFetch1;
      end
      StHalt: halted = 1'b1;
      default: state_d = StFetch1;
    endcase

    // Timeout: a ready arriving on the limit cycle still completes the access.
    if ((state_q inside {StFetch2, StAddr1, StOprd, StStore2}) && !mem_ready) begin
      if (wait_q == LimitCnt) begin
        state_d = StHalt;
        err_d   = 1'b1;
      end else begin
        wait_d = wait_q + CntW'(1);
      end
    end

    if (reset) begin
      mem_rd  = 1'b0;
      mem_wr  = 1'b0;
      ar_ld   = 1'b0;
      ar_src  = 1'b0;
      pc_inc  = 1'b0;
      pc_ld   = 1'b0;
      dr_ld   = 1'b0;
      ir_ld   = 1'b0;
      ac_ld   = 1'b0;
      z_ld    = 1'b0;
      bus_sel = 1'b0;
      alu_sel = '0;
      halted  = 1'b0;
      err     = 1'b0;
    end
  end

endmodule
